// File: rtl/pc_interface_write_bank_pkg.sv
// Shared FSM state encoding and frame-size helper for the PC write bank.
package pc_interface_pkg;

  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,
    S_DATA  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/pc_interface_write_bank_if.sv
// Byte-stream input and register-bank output bundle; i_commit exists only with PC_INTERFACE_WRITE_BANK_SHADOW_EN.
interface pc_interface_write_bank_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic [7:0]                          i_rx_data;
  logic                                i_rx_valid;
  logic                                o_rx_ready;
  logic [(DATA_WIDTH<<ADDR_WIDTH)-1:0] o_data;
  logic [(1<<ADDR_WIDTH)-1:0]          o_wr_strobe;
  logic                                o_err;
  logic                                o_busy;
`ifdef PC_INTERFACE_WRITE_BANK_SHADOW_EN
  logic                                i_commit;

  modport master (output i_rx_data, i_rx_valid, i_commit,
                  input  o_rx_ready, o_data, o_wr_strobe, o_err, o_busy);
  modport slave  (input  i_rx_data, i_rx_valid, i_commit,
                  output o_rx_ready, o_data, o_wr_strobe, o_err, o_busy);
`else
  modport master (output i_rx_data, i_rx_valid,
                  input  o_rx_ready, o_data, o_wr_strobe, o_err, o_busy);
  modport slave  (input  i_rx_data, i_rx_valid,
                  output o_rx_ready, o_data, o_wr_strobe, o_err, o_busy);
`endif
endinterface

// File: rtl/pc_interface_write_bank_frame_rx.sv
// Frame parser: address byte + MSB-first data bytes -> one-cycle wr_en with addr/word; err on bad address or timeout.
// rx_ready drops only during the single write cycle; a byte arriving as the timeout expires is still taken.
module pc_interface_frame_rx
  import pc_interface_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  wr_en,
  output logic                  err
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int BCW = $clog2(BPW + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         state;
  logic [BCW-1:0] byte_cnt;
  logic [TCW-1:0] to_cnt;
  logic           accept;

  assign rx_ready = (state != S_WRITE);
  assign busy     = (state != S_ADDR);
  assign accept   = rx_valid && rx_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_ADDR;
      byte_cnt <= '0;
      to_cnt   <= '0;
      addr     <= '0;
      word     <= '0;
      wr_en    <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_ADDR: begin
          to_cnt   <= '0;
          byte_cnt <= '0;
          if (accept) begin
            if ((rx_data >> ADDR_WIDTH) == 8'd0) begin
              addr  <= rx_data[ADDR_WIDTH-1:0];
              word  <= '0;
              state <= S_DATA;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            word   <= (word << 8) | DATA_WIDTH'(rx_data);
            to_cnt <= '0;
            if (byte_cnt == BCW'(BPW - 1)) begin
              byte_cnt <= '0;
              wr_en    <= 1'b1;
              state    <= S_WRITE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (to_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
            // partial word is dropped; the bank never sees it
            err      <= 1'b1;
            to_cnt   <= '0;
            byte_cnt <= '0;
            word     <= '0;
            state    <= S_ADDR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_WRITE: state <= S_ADDR;
        default: state <= S_ADDR;
      endcase
    end
  end

endmodule

// File: rtl/pc_interface_write_bank.sv
// PC byte stream -> 2**ADDR_WIDTH registers; o_data/o_wr_strobe update 2 edges after the last byte, rx stalls 1 cycle per frame.
// PC_INTERFACE_WRITE_BANK_SHADOW_EN: writes land in a shadow array and reach o_data only on i_commit.
module pc_interface_write_bank
  import pc_interface_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 3,
  parameter int                    TIMEOUT_CYCLES = 100000,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0
) (
  input logic                     i_clk,
  input logic                     i_rst,
  pc_interface_write_bank_if.slave bus
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0]            addr;
  logic [DATA_WIDTH-1:0]            word;
  logic                             wr_en;
  logic [NREG-1:0]                  wr_dec;
  logic [NREG-1:0][DATA_WIDTH-1:0]  regs;

  pc_interface_frame_rx #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .rx_data  (bus.i_rx_data),
    .rx_valid (bus.i_rx_valid),
    .rx_ready (bus.o_rx_ready),
    .busy     (bus.o_busy),
    .addr     (addr),
    .word     (word),
    .wr_en    (wr_en),
    .err      (bus.o_err)
  );

  assign wr_dec = wr_en ? (NREG'(1) << addr) : '0;

  // strobe is registered so it lines up with the register update it announces
  always_ff @(posedge i_clk) begin
    if (i_rst) bus.o_wr_strobe <= '0;
    else       bus.o_wr_strobe <= wr_dec;
  end

  for (genvar k = 0; k < NREG; k++) begin : g_reg
    logic [DATA_WIDTH-1:0] q;
`ifdef PC_INTERFACE_WRITE_BANK_SHADOW_EN
    logic [DATA_WIDTH-1:0] shadow_q;

    // commit samples shadow_q before a same-cycle write lands
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        shadow_q <= RESET_VALUE;
        q        <= RESET_VALUE;
      end else begin
        if (wr_dec[k])    shadow_q <= word;
        if (bus.i_commit) q        <= shadow_q;
      end
    end
`else
    always_ff @(posedge i_clk) begin
      if (i_rst)          q <= RESET_VALUE;
      else if (wr_dec[k]) q <= word;
    end
`endif
    assign regs[k] = q;
  end

  assign bus.o_data = regs;

endmodule

// File: tb/tb_pc_interface_write_bank.sv
// Directed bench: frame-level model checked every cycle plus literal checks per scenario.
module tb_pc_interface_write_bank;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int TO   = 16;
  localparam int NREG = 1 << AW;
  localparam int BPW  = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pc_interface_write_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  pc_interface_write_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .RESET_VALUE(16'h0000)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_of(input int k);
    return bus.o_data[k*DW +: DW];
  endfunction

  // ---------------- frame-level reference model ----------------
  logic [DW-1:0]   m_vis    [NREG];
  logic [DW-1:0]   m_shadow [NREG];
  logic [7:0]      m_frame  [$];
  int              m_idle;
  bit              m_wr;
  int              m_wa;
  logic [DW-1:0]   m_ww;
  logic [NREG-1:0] m_strobe;
  bit              m_err, m_busy, m_rdy;
  bit              m_ok = 0;

  always @(posedge clk) begin
    bit c;
    c = 1'b0;
`ifdef PC_INTERFACE_WRITE_BANK_SHADOW_EN
    c = bus.i_commit;
`endif
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        m_vis[k]    = '0;
        m_shadow[k] = '0;
      end
      m_frame.delete();
      m_idle = 0; m_wr = 0; m_strobe = '0; m_err = 0; m_busy = 0; m_rdy = 1;
      m_ok = 1;
    end else begin
      m_strobe = '0;
      m_err    = 0;
      if (c) for (int k = 0; k < NREG; k++) m_vis[k] = m_shadow[k];
      if (m_wr) begin
`ifdef PC_INTERFACE_WRITE_BANK_SHADOW_EN
        m_shadow[m_wa] = m_ww;
`else
        m_vis[m_wa] = m_ww;
`endif
        m_strobe[m_wa] = 1'b1;
        m_wr = 0;
      end else if (bus.i_rx_valid) begin
        m_idle = 0;
        if (m_frame.size() == 0) begin
          if (int'(bus.i_rx_data) < NREG) m_frame.push_back(bus.i_rx_data);
          else m_err = 1;
        end else begin
          m_frame.push_back(bus.i_rx_data);
          if (m_frame.size() == 1 + BPW) begin
            m_wa = int'(m_frame[0]);
            m_ww = '0;
            for (int i = 1; i <= BPW; i++) m_ww = (m_ww << 8) | DW'(m_frame[i]);
            m_wr = 1;
            m_frame.delete();
          end
        end
      end else if (m_frame.size() > 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_err = 1;
          m_frame.delete();
          m_idle = 0;
        end
      end
      m_busy = (m_frame.size() > 0) || m_wr;
      m_rdy  = !m_wr;
    end
  end

  always @(negedge clk) begin
    logic [NREG*DW-1:0] f;
    if (m_ok) begin
      for (int k = 0; k < NREG; k++) f[k*DW +: DW] = m_vis[k];
      check("model o_data", bus.o_data, f);
      check("model o_wr_strobe", bus.o_wr_strobe, m_strobe);
      check("model o_err", bus.o_err, m_err);
      check("model o_busy", bus.o_busy, m_busy);
      check("model o_rx_ready", bus.o_rx_ready, m_rdy);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_rx_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n == 10) begin
      checks++; errors++;
      $display("FAIL send_byte: o_rx_ready stuck at 0, expected 1");
    end
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic do_commit();
`ifdef PC_INTERFACE_WRITE_BANK_SHADOW_EN
    @(negedge clk);
    bus.i_commit = 1'b1;
    @(negedge clk);
    bus.i_commit = 1'b0;
`endif
  endtask

  bit cnt_en  = 0;
  int low_cnt = 0;
  always @(negedge clk) if (cnt_en && !bus.o_rx_ready) low_cnt++;

  logic [7:0] b2b [6];

  initial begin
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
`ifdef PC_INTERFACE_WRITE_BANK_SHADOW_EN
    bus.i_commit   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset o_data", bus.o_data, '0);
    check("reset o_rx_ready", bus.o_rx_ready, 1);
    check("reset o_busy", bus.o_busy, 0);
    check("reset o_wr_strobe", bus.o_wr_strobe, 0);

    // 1: basic frame and write latency
    send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
    check("t1 no early strobe", bus.o_wr_strobe, 0);
    check("t1 busy in write", bus.o_busy, 1);
    @(negedge clk);
    check("t1 strobe", bus.o_wr_strobe, 8'b0000_0100);
    @(negedge clk);
    check("t1 strobe one cycle", bus.o_wr_strobe, 0);
    do_commit();
    check("t1 reg2", reg_of(2), 16'hABCD);
    check("t1 reg1 untouched", reg_of(1), 16'h0000);

    // 2: bad address then good frame
    send_byte(8'h09);
    check("t2 err pulse", bus.o_err, 1);
    check("t2 not busy", bus.o_busy, 0);
    @(negedge clk);
    check("t2 err cleared", bus.o_err, 0);
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    @(negedge clk);
    do_commit();
    check("t2 reg1", reg_of(1), 16'h1234);

    // 3: inter-byte timeout
    send_byte(8'h03); send_byte(8'h55);
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      check("t3 no early err", bus.o_err, 0);
    end
    @(negedge clk);
    check("t3 timeout err", bus.o_err, 1);
    check("t3 idle after timeout", bus.o_busy, 0);
    do_commit();
    check("t3 reg3 unchanged", reg_of(3), 16'h0000);

    // 4: back-to-back frames with valid held high
    b2b = '{8'h06, 8'hDE, 8'hAD, 8'h07, 8'hBE, 8'hEF};
    low_cnt = 0;
    cnt_en = 1;
    bus.i_rx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int n;
      n = 0;
      while (!bus.o_rx_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      bus.i_rx_data = b2b[i];
      @(negedge clk);
    end
    bus.i_rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    cnt_en = 0;
    check("t4 ready low cycles", low_cnt, 2);
    do_commit();
    check("t4 reg6", reg_of(6), 16'hDEAD);
    check("t4 reg7", reg_of(7), 16'hBEEF);

    // 5: reset mid-frame
    send_byte(8'h05); send_byte(8'h77);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5 busy after reset", bus.o_busy, 0);
    check("t5 regs after reset", bus.o_data, '0);
    send_byte(8'h05); send_byte(8'h9A); send_byte(8'hBC);
    @(negedge clk);
    do_commit();
    check("t5 reg5", reg_of(5), 16'h9ABC);

`ifdef PC_INTERFACE_WRITE_BANK_SHADOW_EN
    // 6: shadow stage and commit ordering
    send_byte(8'h00); send_byte(8'h00); send_byte(8'hFF);
    @(negedge clk);
    check("t6 strobe reg0", bus.o_wr_strobe, 8'b0000_0001);
    check("t6 o_data held", reg_of(0), 16'h0000);
    do_commit();
    check("t6 committed reg0", reg_of(0), 16'h00FF);
    send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    bus.i_commit = 1'b1;
    @(negedge clk);
    bus.i_commit = 1'b0;
    check("t6 commit in write cycle", reg_of(0), 16'h00FF);
    do_commit();
    check("t6 later commit", reg_of(0), 16'h1122);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
